// File: rtl/hs_ram_port.sv
// Work-RAM port arbiter between the game CPU and the hiscore engine; the engine owns the port only while the CPU is paused.
// Optional macro HS_RAM_PORT_STATS_EN enables the hs_wr_count counter of hiscore writes that reached RAM.
module hs_ram_port #(
  parameter logic [15:0] RAM_BASE = 16'h8000,
  parameter int unsigned RAM_AW   = 11,
  parameter int unsigned SETTLE   = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              paused,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  input  logic              hs_access_read,
  input  logic              hs_access_write,
  output logic [7:0]        hs_data_out,
  output logic              hs_grant,
  output logic              hs_drop,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  output logic [7:0]        hs_wr_count
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] ST_CPU    = 2'b00;
  localparam logic [1:0] ST_SETTLE = 2'b01;
  localparam logic [1:0] ST_HS     = 2'b10;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_grant;
  logic              r_drop;
  logic [7:0]        r_rd_data;
  logic              r_rd_req;
  logic              r_rd_ok;

  logic [1:0]        w_state_nx;
  logic [CW-1:0]     w_cnt_nx;
  logic [15:0]       w_diff;
  logic              w_in_range;
  logic              w_hs_sel;
  logic              w_hs_we;
  logic              w_drop_set;
  logic              w_unused;

  // Hiscore intent is informational only; writes are qualified by hs_write alone.
  assign w_unused = hs_access_write;

  assign w_diff     = hs_address - RAM_BASE;
  assign w_in_range = ({16'h0000, w_diff} < (32'd1 << RAM_AW));

  // Next state, RAM mux and hiscore write qualification.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_hs_sel   = (r_state == ST_HS) && !reset;
    w_hs_we    = 1'b0;
    w_drop_set = 1'b0;
    ram_addr   = cpu_addr;
    ram_din    = cpu_din;
    ram_we     = cpu_we;

    case (r_state)
      ST_CPU: begin
        if (paused) begin
          w_state_nx = ST_SETTLE;
          w_cnt_nx   = CW'(SETTLE - 1);
        end
      end
      ST_SETTLE: begin
        // Counter reaching zero on this cycle hands the port over.
        if (!paused) begin
          w_state_nx = ST_CPU;
        end else if (r_cnt <= CW'(1)) begin
          w_state_nx = ST_HS;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx   = r_cnt - CW'(1);
        end
      end
      ST_HS: begin
        if (!paused) begin
          w_state_nx = ST_CPU;
        end
      end
      default: begin
        w_state_nx = ST_CPU;
      end
    endcase

    if (w_hs_sel) begin
      w_hs_we  = hs_write && w_in_range;
      ram_addr = w_diff[RAM_AW-1:0];
      ram_din  = hs_data_in;
      ram_we   = w_hs_we;
    end
    w_drop_set = hs_write && !w_hs_we;
  end

  // State, grant, drop flag and two-stage read pipeline.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= ST_CPU;
      r_cnt     <= '0;
      r_grant   <= 1'b0;
      r_drop    <= 1'b0;
      r_rd_data <= 8'h00;
      r_rd_req  <= 1'b0;
      r_rd_ok   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_grant  <= (w_state_nx == ST_HS);
      r_rd_req <= hs_access_read;
      r_rd_ok  <= hs_access_read && w_hs_sel && w_in_range;
      if (w_drop_set) begin
        r_drop <= 1'b1;
      end
      if (r_rd_req) begin
        r_rd_data <= r_rd_ok ? ram_dout : 8'h00;
      end
    end
  end

  assign hs_grant    = r_grant;
  assign hs_drop     = r_drop;
  assign hs_data_out = r_rd_data;

`ifdef HS_RAM_PORT_STATS_EN
  logic [7:0] r_wr_cnt;

  // Saturating count of hiscore writes that reached RAM.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_cnt <= 8'h00;
    end else if (w_hs_we && (r_wr_cnt != 8'hFF)) begin
      r_wr_cnt <= r_wr_cnt + 8'd1;
    end
  end

  assign hs_wr_count = r_wr_cnt;
`else
  assign hs_wr_count = 8'h00;
`endif

endmodule
